// File: rtl/alu_rs_multi.sv
// Multi-entry ALU reservation station: CDB operand snooping, oldest-ready dispatch, back-pressured result register.
// Optional ALU_RS_FLUSH_EN adds flush_i, which clears all slots and the result register.
module alu_rs_multi #(
    parameter int ENTRIES = 4,
    parameter int XLEN    = 32,
    parameter int FU_NUM  = 8,
    parameter int FU_LOG  = 3,
    parameter int ROB_LOG = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
`ifdef ALU_RS_FLUSH_EN
    input  logic                       flush_i,
`endif
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [2:0]                 issue_op_i,
    input  logic [ROB_LOG-1:0]         issue_rob_i,
    input  logic                       issue_rj_i,
    input  logic                       issue_rk_i,
    input  logic [FU_LOG-1:0]          issue_qj_i,
    input  logic [FU_LOG-1:0]          issue_qk_i,
    input  logic [XLEN-1:0]            issue_vj_i,
    input  logic [XLEN-1:0]            issue_vk_i,
    input  logic [FU_NUM-1:0]          cdb_valid_i,
    input  logic [FU_NUM*XLEN-1:0]     cdb_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ROB_LOG-1:0]         out_rob_o,
    output logic [XLEN-1:0]            out_value_o,
    output logic [$clog2(ENTRIES):0]   occupancy_o
);
    localparam int OCC_W = $clog2(ENTRIES) + 1;
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int SH_W  = $clog2(XLEN);

    typedef struct packed {
        logic [2:0]         op;
        logic [ROB_LOG-1:0] rob;
        logic               rj;
        logic               rk;
        logic [FU_LOG-1:0]  qj;
        logic [FU_LOG-1:0]  qk;
        logic [XLEN-1:0]    vj;
        logic [XLEN-1:0]    vk;
    } slot_t;

    slot_t               slot_q [ENTRIES];
    slot_t               slot_d [ENTRIES];
    // older_q[a][b] set means slot a was issued before slot b
    logic [ENTRIES-1:0]  older_q [ENTRIES];
    logic [ENTRIES-1:0]  older_d [ENTRIES];
    logic [ENTRIES-1:0]  valid_q, valid_d, ready, pick;
    logic [IDX_W-1:0]    free_idx, sel_idx;
    logic                do_issue, do_disp, flush;
    logic                out_valid_q, out_valid_d;
    logic [ROB_LOG-1:0]  out_rob_q, out_rob_d;
    logic [XLEN-1:0]     out_value_q, out_value_d, res;
    logic [OCC_W-1:0]    occ_q, occ_d;
    slot_t               sel_s;

`ifdef ALU_RS_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign issue_ready_o = ~&valid_q;
    assign out_valid_o   = out_valid_q;
    assign out_rob_o     = out_rob_q;
    assign out_value_o   = out_value_q;
    assign occupancy_o   = occ_q;

    always_comb begin
        ready    = '0;
        pick     = '0;
        free_idx = '0;
        sel_idx  = '0;
        for (int i = 0; i < ENTRIES; i++)
            ready[i] = valid_q[i] & slot_q[i].rj & slot_q[i].rk;
        for (int i = 0; i < ENTRIES; i++) begin
            pick[i] = ready[i];
            for (int j = 0; j < ENTRIES; j++)
                if (ready[j] && older_q[j][i]) pick[i] = 1'b0;
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
            if (pick[i])     sel_idx  = IDX_W'(i);
        end
    end

    assign do_disp  = (|ready) && (!out_valid_q || out_ready_i);
    assign do_issue = issue_valid_i && issue_ready_o && !flush;
    assign sel_s    = slot_q[sel_idx];

    always_comb begin
        res = '0;
        case (sel_s.op)
            3'd0: res = sel_s.vj + sel_s.vk;
            3'd1: res = sel_s.vj - sel_s.vk;
            3'd2: res = sel_s.vj * sel_s.vk;
            3'd3: res = XLEN'($signed(sel_s.vj) >= $signed(sel_s.vk));
            3'd4: res = sel_s.vj << sel_s.vk[SH_W-1:0];
            3'd5: res = sel_s.vj >> sel_s.vk[SH_W-1:0];
            3'd6: res = sel_s.vj & sel_s.vk;
            default: res = sel_s.vj | sel_s.vk;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        slot_d      = slot_q;
        older_d     = older_q;
        out_valid_d = out_valid_q;
        out_rob_d   = out_rob_q;
        out_value_d = out_value_q;
        occ_d       = occ_q + OCC_W'(do_issue) - OCC_W'(do_disp);

        for (int i = 0; i < ENTRIES; i++) begin
            if (!slot_q[i].rj && cdb_valid_i[slot_q[i].qj]) begin
                slot_d[i].rj = 1'b1;
                slot_d[i].vj = cdb_data_i[slot_q[i].qj*XLEN +: XLEN];
            end
            if (!slot_q[i].rk && cdb_valid_i[slot_q[i].qk]) begin
                slot_d[i].rk = 1'b1;
                slot_d[i].vk = cdb_data_i[slot_q[i].qk*XLEN +: XLEN];
            end
        end

        if (do_disp) begin
            valid_d[sel_idx] = 1'b0;
            out_valid_d      = 1'b1;
            out_rob_d        = sel_s.rob;
            out_value_d      = res;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (do_issue) begin
            valid_d[free_idx]    = 1'b1;
            slot_d[free_idx].op  = issue_op_i;
            slot_d[free_idx].rob = issue_rob_i;
            slot_d[free_idx].qj  = issue_qj_i;
            slot_d[free_idx].qk  = issue_qk_i;
            slot_d[free_idx].rj  = issue_rj_i || cdb_valid_i[issue_qj_i];
            slot_d[free_idx].rk  = issue_rk_i || cdb_valid_i[issue_qk_i];
            slot_d[free_idx].vj  = issue_rj_i ? issue_vj_i : cdb_data_i[issue_qj_i*XLEN +: XLEN];
            slot_d[free_idx].vk  = issue_rk_i ? issue_vk_i : cdb_data_i[issue_qk_i*XLEN +: XLEN];
            for (int j = 0; j < ENTRIES; j++)
                older_d[j][free_idx] = valid_q[j];
            older_d[free_idx] = '0;
        end

        if (flush) begin
            valid_d     = '0;
            out_valid_d = 1'b0;
            occ_d       = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_rob_q   <= '0;
            out_value_q <= '0;
            occ_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_rob_q   <= out_rob_d;
            out_value_q <= out_value_d;
            occ_q       <= occ_d;
        end
    end

    // Payload and age state are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk_i) begin
        slot_q  <= slot_d;
        older_q <= older_d;
    end
endmodule

// File: doc/alu_rs_multi.md
Name: alu_rs_multi

Overview:
- Multi-entry, parametrised ALU reservation station; successor to the single-slot ALU station in the Tomasulo core.
- Holds up to ENTRIES pending ALU ops and snoops the common data bus for missing operands.
- Each cycle, dispatches the oldest ready op into a one-stage ALU with a registered, back-pressured result port toward the reorder buffer.
- Sits between the issue stage and the ROB write port.

Parameters:
- ENTRIES, 4: number of station slots (2..16).
- XLEN, 32: operand/result width.
- FU_NUM, 8: functional units on the CDB (tag space).
- FU_LOG, 3: tag width, clog2(FU_NUM).
- ROB_LOG, 4: reorder-buffer index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue request.
- issue_ready  out  1  at least one free slot.
- issue_op  in  3  0=ADD 1=SUB 2=MUL 3=BGE 4=SHL 5=SHR 6=AND 7=OR.
- issue_rob  in  ROB_LOG  destination ROB position.
- issue_rj / issue_rk  in  1  operand j/k value already valid.
- issue_qj / issue_qk  in  FU_LOG  producing FU tag when not ready.
- issue_vj / issue_vk  in  XLEN  operand value when ready.
- cdb_valid  in  FU_NUM  per-FU broadcast strobe.
- cdb_data  in  FU_NUM*XLEN  FU i value at bits [i*XLEN +: XLEN].
- out_valid  out  1  result register full.
- out_ready  in  1  ROB accepts result.
- out_rob  out  ROB_LOG  result ROB position.
- out_value  out  XLEN  result.
- occupancy  out  clog2(ENTRIES)+1  number of valid slots.

Behaviour:
- Reset: all slots invalid; out_valid=0, out_rob=0, out_value=0, occupancy=0, issue_ready=1. Reset mid-operation discards all slots and any held result.
- issue_ready = any slot free, computed from registered state only; it does not count a same-cycle dispatch.
- Issue on issue_valid&&issue_ready writes the lowest-index free slot.
- Same-cycle capture at issue: a non-ready operand whose cdb_valid[q] is high in the issue cycle is captured immediately, value from the CDB slice.
- Snoop: every cycle, each waiting operand with cdb_valid[q]=1 latches its CDB slice and sets its ready flag. A slot is ready when both flags are set.
- Age: each slot has an issue-order rank (age matrix or sequence stamp). Select picks the oldest ready slot; ties cannot occur.
- Dispatch fires when a ready slot exists and the result register can be written, i.e. (!out_valid || out_ready).
  - On dispatch: compute result, load out_rob/out_value, set out_valid, free the slot, update ranks.
  - out_valid clears when out_ready is high and no dispatch occurs that cycle.
- Latency:
  - Issue with both operands ready at edge t: slot ready after t, dispatch at t+1, out_valid visible after t+1.
  - Operand arriving on CDB at edge t: dispatch no earlier than t+1.
- Back-pressure: out_valid&&!out_ready holds out_* stable and stalls dispatch. Slots keep snooping.
- Full: occupancy==ENTRIES drops issue_ready. A slot freed by dispatch is usable from the next cycle.
- Arithmetic:
  - ADD/SUB/MUL: modulo 2^XLEN, low XLEN bits.
  - BGE: signed vj>=vk gives 1, else 0, zero-extended.
  - SHL/SHR: logical shift by vk[clog2(XLEN)-1:0].
  - AND/OR: bitwise.
- Simultaneous issue and dispatch in one cycle are both legal; occupancy is net of the two.

Optional Feature:
- Macro ALU_RS_FLUSH_EN adds input flush (1 bit).
- With the macro: flush=1 at an edge invalidates all slots and clears out_valid, taking priority over issue and dispatch; issue_valid that cycle is ignored.
- Without the macro: no flush port; only reset clears state.

Test Plan:
- Reset, then issue ADD rob=3, vj=5, vk=7, both ready -> out_valid one cycle after the issue edge, out_rob=3, out_value=12; occupancy returns to 0.
- Issue SUB rob=1 with qj=2 not ready, vk=1; two cycles later cdb_valid[2]=1 with slice=10 -> out_value=9 the cycle after the snoop. Same case with cdb_valid[2] high in the issue cycle -> captured, dispatched next cycle.
- Fill all 4 slots with ready ops, out_ready=0 -> issue_ready=0, out_* held stable. Raise out_ready -> results appear in issue order, one per cycle.
- Issue A (waits on FU 5), then B (ready) -> B completes first. Then broadcast FU 5 -> A completes. BGE vj=0xFFFFFFFF, vk=0 -> 0; SHL vj=1, vk=33 -> 2.
- Assert reset while 3 slots are busy and out_valid=1 -> next cycle out_valid=0, occupancy=0, issue_ready=1.
- Flush (ALU_RS_FLUSH_EN defined) with 2 slots busy and issue_valid=1 -> slots cleared, issued op dropped, out_valid=0.
